// File: rtl/ntt_bitrev_pkg.sv
// ntt_bitrev_pkg: shared types and helpers for the ping-pong bit-reversal buffer.
package ntt_bitrev_pkg;

  localparam int unsigned NUM_BANKS = 2;
  localparam int unsigned MAX_LOG_N = 16;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Reverse the low log_n bits of idx; bits above log_n come back as zero.
  function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] idx,
                                                  input int unsigned log_n);
    logic [MAX_LOG_N-1:0] r;
    r = {<<{idx}};
    return r >> (MAX_LOG_N - log_n);
  endfunction

endpackage

// File: rtl/bitrev_dp_ram.sv
// bitrev_dp_ram: simple dual-port RAM holding both ping-pong banks.
// Address MSB selects the bank; the read port is registered with an enable.
module bitrev_dp_ram
  import ntt_bitrev_pkg::*;
#(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned LOG_N  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [LOG_N:0]    wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [LOG_N:0]    rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_BANKS << LOG_N];

  // Write port; storage itself is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its value whenever rd_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ntt_bitrev_pingpong.sv
// ntt_bitrev_pingpong: streaming bit-reversal reorder buffer, two-bank ping-pong.
// One bank fills in natural order while the other drains in bit-reversed order.
// Optional macro NTT_BITREV_MODE_EN adds a per-frame 'mode' input
// (0 = bit-reversed drain, 1 = natural-order drain).
module ntt_bitrev_pingpong
  import ntt_bitrev_pkg::*;
#(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned LOG_N  = 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef NTT_BITREV_MODE_EN
  input  logic              mode,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG_N-1:0]  out_idx,
  output logic              out_last,
  output logic              frame_done
);

  localparam logic [LOG_N-1:0] CNT_MAX = '1;

  bank_state_t [NUM_BANKS-1:0] bank_st;
  bank_state_t [NUM_BANKS-1:0] bank_st_nxt;
  logic                        wr_bank;
  logic                        rd_bank;
  logic [LOG_N-1:0]            wr_cnt;
  logic [LOG_N-1:0]            rd_cnt;
  logic                        ready_en;
  logic                        wr_fire;
  logic                        rd_issue;
  logic [LOG_N-1:0]            rd_rev;
  logic [LOG_N-1:0]            rd_idx;

  assign in_ready = ready_en &&
                    (bank_st[wr_bank] == EMPTY || bank_st[wr_bank] == FILLING);
  assign wr_fire  = in_valid && in_ready;
  assign rd_issue = (bank_st[rd_bank] == FULL || bank_st[rd_bank] == DRAINING) &&
                    (!out_valid || out_ready);
  assign rd_rev   = LOG_N'(bitrev(MAX_LOG_N'(rd_cnt), LOG_N));

`ifdef NTT_BITREV_MODE_EN
  logic [NUM_BANKS-1:0] bank_mode;

  // Latch the drain order on each frame's first write; later mode changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_mode <= '0;
    end else if (wr_fire && bank_st[wr_bank] == EMPTY) begin
      bank_mode[wr_bank] <= mode;
    end
  end

  assign rd_idx = bank_mode[rd_bank] ? rd_cnt : rd_rev;
`else
  assign rd_idx = rd_rev;
`endif

  // Bank state transitions; writer and reader never own the same bank at once.
  always_comb begin
    bank_st_nxt = bank_st;
    if (wr_fire)  bank_st_nxt[wr_bank] = (wr_cnt == CNT_MAX) ? FULL  : FILLING;
    if (rd_issue) bank_st_nxt[rd_bank] = (rd_cnt == CNT_MAX) ? EMPTY : DRAINING;
  end

  // Bank state register and ready gating held off until the cycle after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) bank_st[b] <= EMPTY;
      ready_en <= 1'b0;
    end else begin
      bank_st  <= bank_st_nxt;
      ready_en <= 1'b1;
    end
  end

  // Write pointer: counter wraps naturally and flips banks at the end of a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_cnt == CNT_MAX) wr_bank <= ~wr_bank;
    end
  end

  // Read pointer: advances once per issued read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_issue) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_cnt == CNT_MAX) rd_bank <= ~rd_bank;
    end
  end

  // Output sidebands registered alongside the RAM read; held while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (rd_issue) begin
      out_valid <= 1'b1;
      out_idx   <= rd_idx;
      out_last  <= (rd_cnt == CNT_MAX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign frame_done = out_valid && out_ready && out_last;

  bitrev_dp_ram #(
    .DATA_W (DATA_W),
    .LOG_N  (LOG_N)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_cnt}),
    .wr_data (in_data),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank, rd_idx}),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_ntt_bitrev_pingpong.sv
// tb_ntt_bitrev_pingpong: directed self-checking bench, LOG_N=3, DATA_W=13.
module tb_ntt_bitrev_pingpong;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned LOG_N  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [LOG_N-1:0]  out_idx;
  logic              out_last;
  logic              frame_done;
`ifdef NTT_BITREV_MODE_EN
  logic              mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  ntt_bitrev_pingpong #(
    .DATA_W (DATA_W),
    .LOG_N  (LOG_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef NTT_BITREV_MODE_EN
    .mode       (mode),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    out_ready = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("in_ready_release_same_cycle", in_ready, 0);
    cyc();
    chk("in_ready_after_release", in_ready, 1);

    // Single frame, latency and bit-reversed order
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 13'(i);
      #1;
      chk("t1_in_ready", in_ready, 1);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("t1_valid_t_plus_1", out_valid, 0);
    cyc();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, rev[k]);
      chk("t1_out_idx", out_idx, rev[k]);
      chk("t1_out_last", out_last, (k == 7) ? 1 : 0);
      chk("t1_frame_done", frame_done, (k == 7) ? 1 : 0);
      cyc();
    end
    #1;
    chk("t1_valid_after", out_valid, 0);

    // Two back-to-back frames at full rate
    for (int c = 0; c < 25; c++) begin
      in_valid = (c < 16);
      in_data  = 13'(c);
      #1;
      if (c < 16) chk("t2_in_ready", in_ready, 1);
      if (c >= 9) begin
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, ((c - 9) / 8) * 8 + rev[(c - 9) % 8]);
        chk("t2_out_last", out_last, ((c - 9) % 8 == 7) ? 1 : 0);
      end else begin
        chk("t2_out_valid_idle", out_valid, 0);
      end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("t2_valid_after", out_valid, 0);

    // Backpressure mid-drain
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 13'(32'h100 + i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk("t3_stall_valid", out_valid, 1);
          chk("t3_stall_data", out_data, 32'h102);
          chk("t3_stall_idx", out_idx, 2);
          cyc();
        end
        out_ready = 1'b1;
      end
      #1;
      chk("t3_out_valid", out_valid, 1);
      chk("t3_out_data", out_data, 32'h100 + rev[k]);
      chk("t3_out_idx", out_idx, rev[k]);
      chk("t3_frame_done", frame_done, (k == 7) ? 1 : 0);
      cyc();
    end
    #1;
    chk("t3_valid_after", out_valid, 0);

    // Both banks full, then release
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 13'(32'h200 + i);
      #1;
      chk("t4_in_ready_fill", in_ready, 1);
      cyc();
    end
    #1;
    chk("t4_in_ready_full", in_ready, 0);
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t4_hold_in_ready", in_ready, 0);
      chk("t4_hold_data", out_data, 32'h200);
      cyc();
    end
    out_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      #1;
      chk("t4_in_ready_drain", in_ready, (r >= 7) ? 1 : 0);
      chk("t4_out_valid", out_valid, 1);
      chk("t4_out_data", out_data, 32'h200 + (r / 8) * 8 + rev[r % 8]);
      cyc();
    end
    #1;
    chk("t4_valid_after", out_valid, 0);

    // Reset mid-frame discards partial input
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 13'(32'h300 + i);
      cyc();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_idx", out_idx, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    cyc();
    cyc();
    chk("t5_rst_data_held", out_data, 0);
    reset = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 13'(32'h1E00 + i);
      #1;
      chk("t5_in_ready", in_ready, 1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t5_out_valid", out_valid, 1);
      chk("t5_out_data", out_data, 32'h1E00 + rev[k]);
      chk("t5_out_idx", out_idx, rev[k]);
      cyc();
    end

`ifdef NTT_BITREV_MODE_EN
    // Per-frame mode: frame A natural, frame B bit-reversed despite mid-frame toggle
    for (int c = 0; c < 25; c++) begin
      in_valid = (c < 16);
      in_data  = 13'(32'hA00 + c);
      mode     = (c < 8) ? 1'b1 : ((c < 12) ? 1'b0 : 1'b1);
      #1;
      if (c >= 9) begin
        chk("t6_out_valid", out_valid, 1);
        chk("t6_out_data", out_data, 32'hA00 + ((c - 9) / 8) * 8 +
            (((c - 9) < 8) ? (c - 9) : rev[(c - 9) % 8]));
        chk("t6_out_idx", out_idx, ((c - 9) < 8) ? (c - 9) : rev[(c - 9) % 8]);
      end
      cyc();
    end
    in_valid = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_bitrev_pingpong.md
Name: ntt_bitrev_pingpong

Overview:
- Parametrised streaming bit-reversal reorder buffer for the NTT datapath; successor to the fixed-size bit_reverse block.
- Two-bank ping-pong RAM. One bank fills in natural order while the other drains in bit-reversed index order, giving full-rate continuous frames.
- Valid/ready handshakes on both sides. Sits between the coefficient source and the NTT2/PE butterfly array.

Parameters:
- DATA_W, 13, coefficient width in bits (matches DATA_SIZE_ARB).
- LOG_N, 8, log2 of frame length; N = 2**LOG_N (matches RING_SIZE = 256).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input coefficient valid
- in_ready  out  1  buffer can accept a coefficient
- in_data  in  DATA_W  coefficient, natural order
- out_valid  out  1  output coefficient valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  coefficient, bit-reversed order
- out_idx  out  LOG_N  natural index of out_data (= bitrev of output position)
- out_last  out  1  high with the final coefficient of a frame
- frame_done  out  1  one-cycle pulse when a frame's last output handshakes

Behaviour:
- Reset (reset=0, async): all state cleared.
  - Both banks EMPTY; wr_bank=0, rd_bank=0; wr_cnt=0, rd_cnt=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, frame_done=0.
  - in_ready=1 is first asserted in the cycle after reset deasserts.
  - A partial frame in progress is discarded; RAM contents are don't-care.
- Per-bank state: EMPTY -> FILLING (first write) -> FULL (Nth write) -> DRAINING (first read issued) -> EMPTY (last read issued).
- Write side:
  - in_ready = (state[wr_bank] is EMPTY or FILLING).
  - On in_valid&&in_ready: RAM[wr_bank][wr_cnt]=in_data, then wr_cnt++.
  - At wr_cnt==N-1: the bank goes FULL, wr_bank toggles, wr_cnt wraps to 0.
- Read side:
  - A read issues when state[rd_bank] is FULL or DRAINING and (!out_valid || out_ready).
  - Read address = RAM[rd_bank][bitrev(rd_cnt)].
  - RAM read is registered, so out_valid rises the cycle after issue.
  - If out_ready=0 while out_valid=1: no read issues, and out_data/out_idx/out_last hold stable.
  - At rd_cnt==N-1 read issue: the bank goes EMPTY, rd_bank toggles, rd_cnt wraps.
  - out_last is registered alongside that final read.
- Latency: the last input handshake at cycle t gives the first output valid at t+2.
- Throughput: one coefficient per cycle sustained across back-to-back frames with out_ready=1.
- Simultaneous events:
  - The writer completing bank A and the reader emptying bank B in the same cycle update independently.
  - A write to a bank in the same cycle it becomes EMPTY is not possible: in_ready is evaluated from registered state.
- Both banks FULL: in_ready=0 until a read drains the first one.
- frame_done pulses in the cycle where out_valid&&out_ready&&out_last.
- Counter widths are exactly LOG_N; wrap is natural overflow.

Optional Feature:
- Macro NTT_BITREV_MODE_EN.
- Defined:
  - Adds input port mode (1 bit): 0 = bit-reversed output, 1 = natural-order output (INTT post-processing).
  - mode is sampled on each frame's first write handshake and stored per bank.
  - The drain of that bank uses the stored mode; a mid-frame change of mode has no effect.
- Undefined: no port; always bit-reversed.

Decomposition:
- Package ntt_bitrev_pkg:
  - bank_state_t enum (EMPTY, FILLING, FULL, DRAINING).
  - function bitrev(idx, LOG_N).
  - localparam NUM_BANKS=2.
- Sub-module bitrev_dp_ram:
  - Simple dual-port, 2*N x DATA_W, one write port and one registered read port with read enable.
  - Bank select is the address MSB.

Test Plan (LOG_N=3, DATA_W=13):
- Stream 0x000..0x007 with out_ready=1 -> out_data 0,4,2,6,1,5,3,7; out_idx identical. out_last and frame_done on the 8th output, which arrives at t+2 after the last input.
- Two back-to-back frames 0x000..0x00F with in_valid held high -> in_ready never drops, and 16 outputs arrive in consecutive cycles.
- out_ready=0 for 5 cycles mid-drain on frame 0x100..0x107 -> out_data holds (e.g. 0x102) stable, then resumes 0x106,... with no loss or duplicate.
- out_ready=0, push 16 coefficients -> in_ready drops after the 16th. On releasing out_ready, in_ready rises after the first bank fully drains.
- reset pulsed low after 3 inputs, then frame 0x1E00..0x1E07 -> all outputs 0 during reset. The new frame outputs 0x1E00,0x1E04,... with no stale data.
- With NTT_BITREV_MODE_EN: frame A mode=1, frame B mode=0, mode toggled mid-frame B -> A outputs natural order, B outputs bit-reversed.
